// File: rtl/bus_router_pkg.sv
// rtl/bus_router_pkg.sv - shared state type, constants and default board memory map for bus_router
package bus_router_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] RDATA_UNMAPPED = 8'hFF;

    // Region order: 0 RAM, 1 text video, 2 BIOS, 3 graphics (region 0 in the low bits)
    localparam logic [79:0] DEFAULT_BASE = {20'hA0000, 20'hF0000, 20'hB8000, 20'h00000};
    localparam logic [79:0] DEFAULT_MASK = {20'hF0000, 20'hFE000, 20'hFE000, 20'hC0000};
    localparam logic [11:0] DEFAULT_WAIT = 12'h000;

endpackage

// File: rtl/bus_router_decode.sv
// rtl/bus_router_decode.sv - combinational base/mask priority matcher, lowest region index wins
module bus_router_decode
    import bus_router_pkg::*;
#(
    parameter int AW = 20,
    parameter int MW = 18,
    parameter int NR = 4,
    parameter int IW = 2,
    parameter logic [NR*AW-1:0] BASE = DEFAULT_BASE,
    parameter logic [NR*AW-1:0] MASK = DEFAULT_MASK
) (
    input  logic [AW-1:0] address,
    output logic          hit,
    output logic [IW-1:0] index,
    output logic [MW-1:0] local_address
);

    // Scanning from the top down lets the lowest matching index overwrite the rest
    always_comb begin
        hit           = 1'b0;
        index         = '0;
        local_address = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if ((address & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit           = 1'b1;
                index         = IW'(i);
                local_address = MW'(address & ~MASK[i*AW +: AW]);
            end
        end
    end

endmodule

// File: rtl/bus_router.sv
// rtl/bus_router.sv - CPU bus router: region decode, wait states, read capture, ready handshake
// Optional run-time bank relocation of each region window: BUS_ROUTER_BANK_EN
module bus_router
    import bus_router_pkg::*;
#(
    parameter int AW     = 20,
    parameter int MW     = 18,
    parameter int NR     = 4,
    parameter int WAIT_W = 3,
    parameter int BW     = 4,
    parameter logic [NR*AW-1:0]     REGION_BASE = DEFAULT_BASE,
    parameter logic [NR*AW-1:0]     REGION_MASK = DEFAULT_MASK,
    parameter logic [NR*WAIT_W-1:0] REGION_WAIT = DEFAULT_WAIT
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_address,
    input  logic [7:0]      cpu_wdata,
    output logic [7:0]      cpu_rdata,
    output logic            cpu_ready,
    output logic            fault,
    output logic [MW-1:0]   mem_address,
    output logic [7:0]      mem_wdata,
    output logic [NR-1:0]   mem_sel,
    output logic [NR-1:0]   mem_we,
`ifdef BUS_ROUTER_BANK_EN
    input  logic                                  bank_we,
    input  logic [((NR > 1) ? $clog2(NR) : 1)-1:0] bank_region,
    input  logic [BW-1:0]                         bank_value,
`endif
    input  logic [NR*8-1:0] mem_rdata
);

    localparam int IW = (NR > 1) ? $clog2(NR) : 1;

    state_t          state, state_next;
    logic            hit;
    logic [IW-1:0]   dec_index;
    logic [MW-1:0]   dec_local;
    logic [MW-1:0]   access_address;
    logic [IW-1:0]   region;
    logic [WAIT_W-1:0] cnt;

    bus_router_decode #(
        .AW(AW), .MW(MW), .NR(NR), .IW(IW),
        .BASE(REGION_BASE), .MASK(REGION_MASK)
    ) u_decode (
        .address      (cpu_address),
        .hit          (hit),
        .index        (dec_index),
        .local_address(dec_local)
    );

`ifdef BUS_ROUTER_BANK_EN
    logic [BW-1:0] bank [NR];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NR; i++) bank[i] <= '0;
        end else if (bank_we && (int'(bank_region) < NR)) begin
            bank[bank_region] <= bank_value;
        end
    end

    // Bank occupies the top BW bits of the local window; overflow wraps silently
    assign access_address = dec_local + (MW'(bank[dec_index]) << (MW - BW));
`else
    assign access_address = dec_local;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cpu_req) state_next = hit ? ACCESS : RESP;
            ACCESS:  if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cpu_rdata   <= RDATA_UNMAPPED;
            cpu_ready   <= 1'b0;
            fault       <= 1'b0;
            mem_sel     <= '0;
            mem_we      <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            region      <= '0;
            cnt         <= '0;
        end else begin
            cpu_ready <= 1'b0;
            fault     <= 1'b0;
            mem_we    <= '0;
            case (state)
                IDLE: begin
                    if (cpu_req && hit) begin
                        region      <= dec_index;
                        mem_sel     <= NR'(1) << dec_index;
                        mem_we      <= cpu_we ? (NR'(1) << dec_index) : '0;
                        mem_address <= access_address;
                        mem_wdata   <= cpu_wdata;
                        cnt         <= REGION_WAIT[dec_index*WAIT_W +: WAIT_W];
                    end else if (cpu_req) begin
                        cpu_rdata <= RDATA_UNMAPPED;
                        cpu_ready <= 1'b1;
                        fault     <= 1'b1;
                    end
                end
                ACCESS: begin
                    // Read data is captured for writes too, keeping one completion path
                    if (cnt == '0) begin
                        cpu_rdata <= mem_rdata[region*8 +: 8];
                        cpu_ready <= 1'b1;
                        mem_sel   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// tb/tb_bus_router.sv - randomized and directed checks of bus_router against a behavioural map model
module tb_bus_router;
    import bus_router_pkg::*;

    localparam int AW = 20, MW = 18, NR = 5, WAIT_W = 3, BW = 4;
    localparam logic [NR*AW-1:0]     BASE  = {20'h00100, DEFAULT_BASE};
    localparam logic [NR*AW-1:0]     MASK  = {20'hFFF00, DEFAULT_MASK};
    localparam logic [NR*WAIT_W-1:0] WAITS = {3'd1, 3'd2, 3'd1, 3'd3, 3'd0};

    logic            clock = 1'b0;
    logic            resetn;
    logic            cpu_req;
    logic            cpu_we;
    logic [AW-1:0]   cpu_address;
    logic [7:0]      cpu_wdata;
    logic [7:0]      cpu_rdata;
    logic            cpu_ready;
    logic            fault;
    logic [MW-1:0]   mem_address;
    logic [7:0]      mem_wdata;
    logic [NR-1:0]   mem_sel;
    logic [NR-1:0]   mem_we;
    logic [NR*8-1:0] mem_rdata;
    logic            bank_we;
    logic [2:0]      bank_region;
    logic [3:0]      bank_value;

    int n_checks = 0;
    int n_fails  = 0;

    int unsigned m_base [NR] = '{32'h00000, 32'hB8000, 32'hF0000, 32'hA0000, 32'h00100};
    int unsigned m_mask [NR] = '{32'hC0000, 32'hFE000, 32'hFE000, 32'hF0000, 32'hFFF00};
    int          m_wait [NR] = '{0, 3, 1, 2, 1};
    int unsigned m_bank [NR] = '{0, 0, 0, 0, 0};

    bus_router #(
        .AW(AW), .MW(MW), .NR(NR), .WAIT_W(WAIT_W), .BW(BW),
        .REGION_BASE(BASE), .REGION_MASK(MASK), .REGION_WAIT(WAITS)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_address(cpu_address),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .fault      (fault),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
`ifdef BUS_ROUTER_BANK_EN
        .bank_we    (bank_we),
        .bank_region(bank_region),
        .bank_value (bank_value),
`endif
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest-index match; local offset plus bank, modulo 2^MW
    function automatic void model(input logic [19:0] a, output bit h, output int idx,
                                  output logic [17:0] la);
        h = 1'b0; idx = 0; la = '0;
        for (int i = 0; i < NR; i++) begin
            if (!h && ((32'(a) & m_mask[i]) == m_base[i])) begin
                h   = 1'b1;
                idx = i;
                la  = 18'((32'(a) & ~m_mask[i]) + (m_bank[i] << 14));
            end
        end
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_rdata"}, cpu_rdata, 8'hFF);
        check({tag, "_ready"}, cpu_ready, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_sel"}, mem_sel, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_address, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic bank_write(input int r, input int v);
        bank_we = 1'b1; bank_region = 3'(r); bank_value = 4'(v);
        @(posedge clock);
`ifdef BUS_ROUTER_BANK_EN
        if (r < NR) m_bank[r] = 32'(v);
`endif
        @(negedge clock);
        bank_we = 1'b0;
    endtask

    // Called just after a negedge with the DUT idle; returns one negedge into the next idle cycle
    task automatic do_access(input logic [19:0] a, input bit we, input logic [7:0] wd,
                             input logic [39:0] rd, input bit bw, input int br, input int bv);
        bit h; int idx; logic [17:0] la; int w; int last;
        model(a, h, idx, la);
        w    = h ? m_wait[idx] : 0;
        last = h ? w + 2 : 1;
        cpu_req = 1'b1; cpu_address = a; cpu_we = we; cpu_wdata = wd; mem_rdata = rd;
        bank_we = bw; bank_region = 3'(br); bank_value = 4'(bv);
        @(posedge clock);
`ifdef BUS_ROUTER_BANK_EN
        if (bw && br < NR) m_bank[br] = 32'(bv);
`endif
        for (int c = 1; c <= last; c++) begin
            @(negedge clock);
            if (c == 1) begin cpu_req = 1'b0; bank_we = 1'b0; end
            if (h) begin
                check("mem_sel", mem_sel, (c <= w + 1) ? (1 << idx) : 0);
                check("mem_we", mem_we, (c == 1 && we) ? (1 << idx) : 0);
                check("cpu_ready", cpu_ready, 32'(c == last));
                check("fault", fault, 0);
                if (c <= w + 1) begin
                    check("mem_address", mem_address, la);
                    check("mem_wdata", mem_wdata, wd);
                end
                if (c == last) check("cpu_rdata", cpu_rdata, rd[idx*8 +: 8]);
            end else begin
                check("unmapped_ready", cpu_ready, 1);
                check("unmapped_fault", fault, 1);
                check("unmapped_rdata", cpu_rdata, 8'hFF);
                check("unmapped_sel", mem_sel, 0);
                check("unmapped_we", mem_we, 0);
            end
        end
        @(negedge clock);
        check("idle_ready", cpu_ready, 0);
        check("idle_fault", fault, 0);
        check("idle_sel", mem_sel, 0);
    endtask

    initial begin
        logic [19:0] a;
        int r;
        resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
        mem_rdata = '0; bank_we = 1'b0; bank_region = '0; bank_value = '0;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        resetn = 1'b1;
        @(negedge clock);

        do_access(20'h00010, 1'b0, 8'h00, 40'h11_22_33_44_5A, 1'b0, 0, 0);
        check("ram_read_data", cpu_rdata, 8'h5A);
        do_access(20'hB8002, 1'b1, 8'h41, 40'h0, 1'b0, 0, 0);
        do_access(20'hC0000, 1'b0, 8'h00, 40'h12_34_56_78_9A, 1'b0, 0, 0);
        do_access(20'h00100, 1'b0, 8'h00, 40'hEE_DD_CC_BB_AA, 1'b0, 0, 0);
        check("overlap_region0", cpu_rdata, 8'hAA);

`ifdef BUS_ROUTER_BANK_EN
        bank_write(3, 4'hF);
        do_access(20'hA0004, 1'b0, 8'h00, 40'h77_66_55_44_33, 1'b0, 0, 0);
        do_access(20'hA0004, 1'b0, 8'h00, 40'h01_02_03_04_05, 1'b1, 3, 1);
        do_access(20'hA0004, 1'b1, 8'h3C, 40'h09_08_07_06_05, 1'b0, 0, 0);
        bank_write(5, 4'h7);
        do_access(20'h00020, 1'b0, 8'h00, 40'hA1_A2_A3_A4_A5, 1'b0, 0, 0);
`endif

        // Reset in cycle 2 of a W=3 write to the text region
        cpu_req = 1'b1; cpu_address = 20'hB8010; cpu_we = 1'b1; cpu_wdata = 8'h99;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0;
        @(posedge clock);
        #2 resetn = 1'b0;
        #1 check_reset_values("abort");
        for (int i = 0; i < NR; i++) m_bank[i] = 0;
        repeat (2) @(negedge clock);
        check("abort_no_ready", cpu_ready, 0);
        resetn = 1'b1;
        @(negedge clock);
        check("abort_idle_sel", mem_sel, 0);
        do_access(20'hB8004, 1'b0, 8'h00, 40'h00_00_00_C3_00, 1'b0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 5));
            if (r < NR) a = 20'(m_base[r] | ($urandom & ~m_mask[r]));
            else        a = 20'($urandom);
            do_access(a, 1'($urandom), 8'($urandom), {8'($urandom), $urandom},
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
